aes_ctrl: RTL and testbench
===========================

AES_CTRL -- requirements
Module: aes_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, range 0..15: idle cycles between the core round-data load and result capture, covering the combinational 10-round path.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports key_valid input 1, key_in input 128, key_ready output 1  key-load handshake.
REQ-005 SHALL have ports din_valid input 1, din input 128, din_ready output 1  plaintext handshake.
REQ-006 SHALL have ports dout_valid output 1, dout output 128, dout_ready input 1  ciphertext handshake.
REQ-007 SHALL have ports core_in_key output 128, core_in_data output 128  registered operands driven to the AES core.
REQ-008 SHALL have ports core_valid_key_gen, core_valid_round, core_valid_out, each output 1  core strobes.
REQ-009 SHALL have port core_out_data  input 128  core ciphertext.
REQ-010 SHALL have ports busy output 1 (state != IDLE) and key_loaded output 1 (a valid key expansion is held in the core).

Function
REQ-011 SHALL implement FSM states IDLE, KEYGEN, LOAD, SETTLE, CAPTURE, OUTPUT.
REQ-012 key_ready SHALL be 1 only in IDLE; din_ready SHALL be 1 only in IDLE with key_loaded=1 and key_valid=0.
REQ-013 Key handshake at cycle T: key_in registered into core_in_key; KEYGEN at T+1 with core_valid_key_gen=1 for exactly one cycle; IDLE at T+2 with key_loaded=1.
REQ-014 key_valid and din_valid both high in IDLE: key SHALL win; din SHALL NOT be accepted that cycle.
REQ-015 Re-keying with key_loaded=1 SHALL be allowed; key_loaded SHALL stay 1 throughout.
REQ-016 Data handshake at cycle T: din registered into core_in_data; LOAD at T+1 with core_valid_round=1 for one cycle.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by a 4-bit down-counter; SETTLE_CYCLES=0 SHALL go LOAD->CAPTURE directly.
REQ-018 CAPTURE SHALL last one cycle with core_valid_out=1, registering core_out_data into dout.
REQ-019 OUTPUT SHALL hold dout_valid=1 and dout stable until dout_ready=1; on that cycle the FSM SHALL return to IDLE next cycle.
REQ-020 Data-accept-to-dout_valid latency SHALL be SETTLE_CYCLES+3 cycles, independent of dout_ready.
REQ-021 core_in_key SHALL be constant from key acceptance until the next key acceptance; core_in_data SHALL be constant from data acceptance to the next data acceptance.
REQ-022 core_valid_key_gen, core_valid_round and core_valid_out SHALL be mutually exclusive, one-hot with their states, and registered (no combinational path from handshake inputs).
REQ-023 dout SHALL change only in CAPTURE; dout_valid SHALL be 0 in every state except OUTPUT.

Reset
REQ-024 resetn low SHALL asynchronously force IDLE; clear key_loaded, all core strobes, dout_valid, counters; zero core_in_key, core_in_data, dout.
REQ-025 Reset mid-operation (any state) SHALL discard the in-flight block; after release a new key SHALL be required before din_ready asserts.
REQ-026 Outputs after reset: key_ready=1, din_ready=0, busy=0, dout_valid=0.

Configuration
REQ-027 Macro AES_CTRL_BLKCNT_EN defined: SHALL add output blk_count (32 bits), reset to 0, incremented on each dout handshake, wrapping 0xFFFFFFFF->0, cleared on each key acceptance.
REQ-028 Macro undefined: port blk_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-029 Key 000102030405060708090a0b0c0d0e0f, then din 00112233445566778899aabbccddeeff, dout_ready=1 -> dout 69c4e0d86a7b0430d8cdb78070b4c55a, dout_valid 7 cycles after data accept (SETTLE_CYCLES=4).
REQ-030 din_valid=1 before any key -> din_ready stays 0, no core strobe issued; after key load -> accepted.
REQ-031 key_valid and din_valid both high in IDLE with key_loaded=1 -> key accepted, core_valid_key_gen next cycle, din accepted only after return to IDLE.
REQ-032 dout_ready held 0 for 10 cycles in OUTPUT -> dout_valid and dout stable, din_ready=0 throughout; release -> IDLE next cycle.
REQ-033 resetn pulsed low during SETTLE -> all outputs at reset values immediately, key_loaded=0, no core_valid_out pulse.
REQ-034 SETTLE_CYCLES=0 and 15 -> latency 3 and 18 cycles; with AES_CTRL_BLKCNT_EN, 3 blocks -> blk_count=3, re-key -> 0.

Source files
------------

// File: rtl/aes_ctrl_if.sv
// Key, plaintext and ciphertext valid/ready handshakes of aes_ctrl.
interface aes_ctrl_if;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         din_valid;
  logic [127:0] din;
  logic         din_ready;
  logic         dout_valid;
  logic [127:0] dout;
  logic         dout_ready;

  modport master (
    output key_valid, key_in,
    output din_valid, din,
    output dout_ready,
    input  key_ready, din_ready,
    input  dout_valid, dout
  );

  modport slave (
    input  key_valid, key_in,
    input  din_valid, din,
    input  dout_ready,
    output key_ready, din_ready,
    output dout_valid, dout
  );
endinterface

// File: rtl/aes_ctrl.sv
// Sequencer for a combinational AES-128 core: key load, round load, settle, capture.
// Define AES_CTRL_BLKCNT_EN to add the blk_count output.
module aes_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         resetn,
  aes_ctrl_if.slave    bus,
  output logic [127:0] core_in_key,
  output logic [127:0] core_in_data,
  output logic         core_valid_key_gen,
  output logic         core_valid_round,
  output logic         core_valid_out,
  input  logic [127:0] core_out_data,
  output logic         busy,
  output logic         key_loaded
`ifdef AES_CTRL_BLKCNT_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  typedef enum logic [2:0] {
    IDLE, KEYGEN, LOAD, SETTLE, CAPTURE, OUTPUT
  } state_t;

  localparam logic [3:0] CNT_INIT =
    (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       key_hs;
  logic       din_hs;
  logic       kg_nx;
  logic       rnd_nx;
  logic       out_nx;
  logic       dv_nx;

  assign bus.key_ready = (state == IDLE);
  assign bus.din_ready = (state == IDLE) && key_loaded
                       && !bus.key_valid;
  assign key_hs = bus.key_valid && bus.key_ready;
  assign din_hs = bus.din_valid && bus.din_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (key_hs)      state_nx = KEYGEN;
        else if (din_hs) state_nx = LOAD;
      end
      KEYGEN:  state_nx = IDLE;
      LOAD:    state_nx = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
      SETTLE:  if (cnt == 4'd0) state_nx = CAPTURE;
      CAPTURE: state_nx = OUTPUT;
      OUTPUT:  if (bus.dout_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and then flopped.
  always_comb begin
    kg_nx  = 1'b0;
    rnd_nx = 1'b0;
    out_nx = 1'b0;
    dv_nx  = 1'b0;
    unique case (1'b1)
      (state_nx == KEYGEN):  kg_nx  = 1'b1;
      (state_nx == LOAD):    rnd_nx = 1'b1;
      (state_nx == CAPTURE): out_nx = 1'b1;
      (state_nx == OUTPUT):  dv_nx  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_valid_key_gen <= 1'b0;
      core_valid_round   <= 1'b0;
      core_valid_out     <= 1'b0;
      bus.dout_valid     <= 1'b0;
    end else begin
      core_valid_key_gen <= kg_nx;
      core_valid_round   <= rnd_nx;
      core_valid_out     <= out_nx;
      bus.dout_valid     <= dv_nx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_in_key  <= '0;
      core_in_data <= '0;
      bus.dout     <= '0;
      key_loaded   <= 1'b0;
      cnt          <= 4'd0;
    end else begin
      if (key_hs) begin
        core_in_key <= bus.key_in;
        key_loaded  <= 1'b1;
      end
      if (din_hs) core_in_data <= bus.din;
      if (state == CAPTURE) bus.dout <= core_out_data;
      if (state == LOAD) cnt <= CNT_INIT;
      else if (state == SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

`ifdef AES_CTRL_BLKCNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                 blk_count <= 32'd0;
    else if (key_hs)                             blk_count <= 32'd0;
    else if (bus.dout_valid && bus.dout_ready)   blk_count <= blk_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_aes_ctrl.sv
// Self-checking bench for aes_ctrl: directed vector table, corner sequences,
// and a randomized run checked against a transaction timeline model.
module tb_aes_ctrl;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam int S = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Stand-in for the AES core: known answer for the reference vector,
  // otherwise a cheap keyed mix so distinct operands give distinct results.
  function automatic logic [127:0] core_f(input logic [127:0] k,
                                          input logic [127:0] d);
    if (k == K0 && d == P0) return C0;
    return k ^ {d[63:0], d[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  aes_ctrl_if bus();
  logic [127:0] ck, cd, co;
  logic kg, rd, vo, busy, kl;
  assign co = core_f(ck, cd);
`ifdef AES_CTRL_BLKCNT_EN
  logic [31:0] bc, bc0, bc15;
`endif

  aes_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .core_in_key(ck), .core_in_data(cd),
    .core_valid_key_gen(kg), .core_valid_round(rd),
    .core_valid_out(vo), .core_out_data(co),
    .busy(busy), .key_loaded(kl)
`ifdef AES_CTRL_BLKCNT_EN
    , .blk_count(bc)
`endif
  );

  // Two extra instances for the settle-length extremes, driven in lockstep.
  aes_ctrl_if bus0();
  aes_ctrl_if bus15();
  logic xkv = 1'b0;
  logic xdv = 1'b0;
  logic [127:0] xk = '0;
  logic [127:0] xd = '0;
  logic [127:0] ck0, cd0, ck15, cd15;
  logic kg0, rd0, vo0, bs0, kl0, kg15, rd15, vo15, bs15, kl15;
  assign bus0.key_valid  = xkv;
  assign bus0.key_in     = xk;
  assign bus0.din_valid  = xdv;
  assign bus0.din        = xd;
  assign bus0.dout_ready = 1'b1;
  assign bus15.key_valid  = xkv;
  assign bus15.key_in     = xk;
  assign bus15.din_valid  = xdv;
  assign bus15.din        = xd;
  assign bus15.dout_ready = 1'b1;

  aes_ctrl #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0),
    .core_in_key(ck0), .core_in_data(cd0),
    .core_valid_key_gen(kg0), .core_valid_round(rd0),
    .core_valid_out(vo0), .core_out_data(core_f(ck0, cd0)),
    .busy(bs0), .key_loaded(kl0)
`ifdef AES_CTRL_BLKCNT_EN
    , .blk_count(bc0)
`endif
  );

  aes_ctrl #(.SETTLE_CYCLES(15)) dut15 (
    .clk(clk), .resetn(resetn), .bus(bus15),
    .core_in_key(ck15), .core_in_data(cd15),
    .core_valid_key_gen(kg15), .core_valid_round(rd15),
    .core_valid_out(vo15), .core_out_data(core_f(ck15, cd15)),
    .busy(bs15), .key_loaded(kl15)
`ifdef AES_CTRL_BLKCNT_EN
    , .blk_count(bc15)
`endif
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] din;
    int           hold;
    logic [127:0] exp;
  } vec_t;

  task automatic idle_in();
    bus.key_valid  = 1'b0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    bus.key_in     = '0;
    bus.din        = '0;
  endtask

  task automatic do_reset();
    idle_in();
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    int n = 0;
    bus.key_valid = 1'b1;
    bus.key_in    = k;
    #1;
    while (!bus.key_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("key_accept_timeout", n < 50, 1);
    @(negedge clk);
    bus.key_valid = 1'b0;
    #1;
    chk("keygen_strobe", kg, 1);
    chk("keygen_no_round", rd, 0);
    chk("core_in_key", ck, k);
    @(negedge clk); #1;
    chk("keygen_one_cycle", kg, 0);
    chk("key_loaded", kl, 1);
    chk("idle_after_key", busy, 0);
  endtask

  task automatic send_data(input logic [127:0] d, input int hold,
                           input logic [127:0] exp, input int lat_exp);
    int n = 0;
    int lat = 1;
    bus.din_valid = 1'b1;
    bus.din       = d;
    #1;
    while (!bus.din_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("din_accept_timeout", n < 50, 1);
    @(negedge clk);
    bus.din_valid = 1'b0;
    #1;
    chk("round_strobe", rd, 1);
    chk("core_in_data", cd, d);
    while (!bus.dout_valid && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    chk("latency", lat, lat_exp);
    repeat (hold) begin
      chk("hold_valid", bus.dout_valid, 1);
      chk("hold_dout", bus.dout, exp);
      chk("hold_din_ready", bus.din_ready, 0);
      @(negedge clk); #1;
    end
    bus.dout_ready = 1'b1;
    #1;
    chk("dout", bus.dout, exp);
    @(negedge clk);
    bus.dout_ready = 1'b0;
    #1;
    chk("idle_after_out", busy, 0);
    chk("dout_valid_drop", bus.dout_valid, 0);
  endtask

  vec_t tbl[4];

  initial begin
    int free_at, out_at, kacc, dacc, blk;
    bit loaded, idle, pv;
    logic [127:0] mkey, mdin, mexp;
    int l0, l15;

    tbl[0] = '{K0, P0, 0, C0};
    tbl[1] = '{K1, 128'h3243f6a8885a308d313198a2e0370734, 10,
               core_f(K1, 128'h3243f6a8885a308d313198a2e0370734)};
    tbl[2] = '{'1, '0, 3, core_f('1, '0)};
    tbl[3] = '{'0, '1, 1, core_f('0, '1)};

    do_reset();
    chk("rst_key_ready", bus.key_ready, 1);
    chk("rst_din_ready", bus.din_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_key_loaded", kl, 0);
    chk("rst_core_key", ck, 0);

    // Data offered before any key is never accepted.
    bus.din_valid = 1'b1;
    bus.din       = P0;
    repeat (5) begin
      @(negedge clk); #1;
      chk("nokey_din_ready", bus.din_ready, 0);
      chk("nokey_round", rd, 0);
      chk("nokey_busy", busy, 0);
    end
    load_key(K0);
    send_data(P0, 0, C0, S + 3);

    foreach (tbl[i]) begin
      load_key(tbl[i].key);
      send_data(tbl[i].din, tbl[i].hold, tbl[i].exp, S + 3);
    end

    // Key and data together: key wins, data follows after KEYGEN.
    bus.key_valid = 1'b1;
    bus.key_in    = K0;
    bus.din_valid = 1'b1;
    bus.din       = P0;
    #1;
    chk("both_din_ready", bus.din_ready, 0);
    chk("both_key_ready", bus.key_ready, 1);
    load_key(K0);
    chk("rekey_loaded", kl, 1);
    send_data(P0, 0, C0, S + 3);

    // Reset pulse while settling.
    bus.din_valid = 1'b1;
    bus.din       = P0;
    #1;
    chk("pre_settle_ready", bus.din_ready, 1);
    @(negedge clk);
    bus.din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("in_settle_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_key_loaded", kl, 0);
    chk("arst_key_ready", bus.key_ready, 1);
    chk("arst_din_ready", bus.din_ready, 0);
    chk("arst_dout_valid", bus.dout_valid, 0);
    chk("arst_strobes", {kg, rd, vo}, 0);
    chk("arst_core_data", cd, 0);
    chk("arst_dout", bus.dout, 0);
    @(negedge clk);
    resetn = 1'b1;
    bus.din_valid = 1'b1;
    repeat (12) begin
      @(negedge clk); #1;
      chk("post_rst_no_out", vo, 0);
      chk("post_rst_din_ready", bus.din_ready, 0);
      chk("post_rst_dout_valid", bus.dout_valid, 0);
    end
    idle_in();

`ifdef AES_CTRL_BLKCNT_EN
    do_reset();
    chk("blk_rst", bc, 0);
    load_key(K0);
    repeat (3) send_data(P0, 0, C0, S + 3);
    chk("blk_three", bc, 3);
    load_key(K1);
    chk("blk_rekey", bc, 0);
`endif

    // Settle extremes, run in lockstep on the side instances.
    do_reset();
    @(negedge clk);
    xk  = K0;
    xkv = 1'b1;
    @(negedge clk);
    xkv = 1'b0;
    @(negedge clk);
    xd  = P0;
    xdv = 1'b1;
    #1;
    chk("s0_din_ready", bus0.din_ready, 1);
    chk("s15_din_ready", bus15.din_ready, 1);
    @(negedge clk);
    xdv = 1'b0;
    l0  = -1;
    l15 = -1;
    for (int i = 1; i <= 25; i++) begin
      #1;
      if (bus0.dout_valid && l0 < 0) l0 = i;
      if (bus15.dout_valid && l15 < 0) l15 = i;
      @(negedge clk);
    end
    chk("s0_latency", l0, 3);
    chk("s15_latency", l15, 18);
    chk("s0_dout", bus0.dout, C0);
    chk("s15_dout", bus15.dout, C0);

    // Randomized traffic against a timeline model.
    do_reset();
    free_at = 0;
    out_at  = -1;
    kacc    = -10;
    dacc    = -10;
    blk     = 0;
    loaded  = 1'b0;
    mkey    = '0;
    mdin    = '0;
    mexp    = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.key_valid  = ($urandom_range(0, 9) == 0);
      bus.key_in     = {$urandom, $urandom, $urandom, $urandom};
      bus.din_valid  = ($urandom_range(0, 2) == 0);
      bus.din        = {$urandom, $urandom, $urandom, $urandom};
      bus.dout_ready = ($urandom_range(0, 3) == 0);
      #1;
      idle = (c >= free_at) && (out_at < 0);
      pv   = (out_at >= 0) && (c >= out_at);
      chk("r_key_ready", bus.key_ready, idle);
      chk("r_din_ready", bus.din_ready, idle && loaded && !bus.key_valid);
      chk("r_dout_valid", bus.dout_valid, pv);
      chk("r_busy", busy, !idle);
      chk("r_keygen", kg, c == kacc + 1);
      chk("r_round", rd, c == dacc + 1);
      chk("r_out", vo, c == dacc + S + 2);
      chk("r_core_key", ck, mkey);
      chk("r_core_data", cd, mdin);
      if (pv) chk("r_dout", bus.dout, mexp);
`ifdef AES_CTRL_BLKCNT_EN
      chk("r_blk", bc, blk);
`endif
      if (idle && bus.key_valid) begin
        kacc    = c;
        loaded  = 1'b1;
        mkey    = bus.key_in;
        free_at = c + 2;
        blk     = 0;
      end else if (idle && loaded && bus.din_valid) begin
        dacc    = c;
        mdin    = bus.din;
        mexp    = core_f(mkey, bus.din);
        out_at  = c + S + 3;
        free_at = 32'h7fffffff;
      end else if (pv && bus.dout_ready) begin
        out_at  = -1;
        free_at = c + 1;
        blk     = blk + 1;
      end
    end
    idle_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
